// File: rtl/sram_bridge_if.sv
// AVR/SRAM control bundle for sram_bridge: command strobe, serial address bit, read-back enable, busy, SRAM address and strobes.
// Latency: wires only, no logic of its own.
// Backpressure: avr_busy from the slave tells the master that commands are being dropped.
// Ports: master = AVR side / bench, slave = bridge. The data buses are plain inout ports on the bridge.
interface sram_bridge_if #(
    parameter int ADDR_W = 21
);
    logic              avr_req;
    logic [2:0]        avr_ctrl;
    logic              avr_si;
    logic              avr_oe;
    logic              avr_busy;
    logic [ADDR_W-1:0] sram_addr;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;

    modport master (
        output avr_req, avr_ctrl, avr_si, avr_oe,
        input  avr_busy, sram_addr, sram_ce_n, sram_oe_n, sram_we_n
    );

    modport slave (
        input  avr_req, avr_ctrl, avr_si, avr_oe,
        output avr_busy, sram_addr, sram_ce_n, sram_oe_n, sram_we_n
    );
endinterface

// File: rtl/sram_bridge.sv
// AVR-to-SRAM bridge: serial address load, single-byte read/write with programmable strobe length, optional auto-increment.
// Latency: SHIFT/LOAD/CLR act on the accept edge; an access is busy for WAIT_STATES+2 cycles (SETUP, STROBE x N, HOLD).
// Backpressure: while avr_busy=1, commands are dropped rather than queued; read data appears on avr_data once busy falls.
// Ports: avr_clk/avr_rst_n (sync, active-low); bus = command, busy and SRAM address/strobes; avr_data and sram_data are tristate buses.
module sram_bridge #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic              avr_clk,
    input  logic              avr_rst_n,
    sram_bridge_if.slave      bus,
    inout  wire  [DATA_W-1:0] avr_data,
    inout  wire  [DATA_W-1:0] sram_data
);
    typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

    localparam logic [2:0] CMD_SHIFT     = 3'b001;
    localparam logic [2:0] CMD_LOAD      = 3'b010;
    localparam logic [2:0] CMD_READ      = 3'b011;
    localparam logic [2:0] CMD_WRITE     = 3'b100;
    localparam logic [2:0] CMD_READ_INC  = 3'b101;
    localparam logic [2:0] CMD_WRITE_INC = 3'b110;
    localparam logic [2:0] CMD_CLR       = 3'b111;

    state_t            state, state_nxt;
    logic [3:0]        wait_cnt;
    logic              op_rd, op_rd_nxt;
    logic              op_inc, op_inc_nxt;
    logic [ADDR_W-1:0] addr, shift_reg;
    logic [DATA_W-1:0] rd_reg, wr_reg;
    logic              busy_q, ce_n_q, oe_n_q, we_n_q, sram_drv_q;
    logic              busy_nxt, ce_n_nxt, oe_n_nxt, we_n_nxt, sram_drv_nxt;
    logic              cmd_vld, acc_start, strobe_last;

    // Commands only count while idle; anything presented during an access is dropped.
    assign cmd_vld     = (state == IDLE) && bus.avr_req;
    assign strobe_last = (wait_cnt == 4'(WAIT_STATES - 1));

    always_comb begin
        state_nxt  = state;
        op_rd_nxt  = op_rd;
        op_inc_nxt = op_inc;
        acc_start  = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_vld) begin
                    case (bus.avr_ctrl)
                        CMD_READ, CMD_WRITE, CMD_READ_INC, CMD_WRITE_INC: acc_start = 1'b1;
                        default:                                          acc_start = 1'b0;
                    endcase
                end
                if (acc_start) begin
                    state_nxt  = SETUP;
                    op_rd_nxt  = (bus.avr_ctrl == CMD_READ) || (bus.avr_ctrl == CMD_READ_INC);
                    op_inc_nxt = (bus.avr_ctrl == CMD_READ_INC) || (bus.avr_ctrl == CMD_WRITE_INC);
                end
            end
            SETUP:   state_nxt = STROBE;
            STROBE:  if (strobe_last) state_nxt = HOLD;
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Pin values are derived from the next state so every SRAM strobe leaves a flop.
        busy_nxt     = (state_nxt != IDLE);
        ce_n_nxt     = (state_nxt == IDLE);
        oe_n_nxt     = !(op_rd_nxt && ((state_nxt == SETUP) || (state_nxt == STROBE)));
        we_n_nxt     = !(!op_rd_nxt && (state_nxt == STROBE));
        sram_drv_nxt = !op_rd_nxt && (state_nxt != IDLE);
    end

    always_ff @(posedge avr_clk) begin
        if (!avr_rst_n) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            op_rd      <= 1'b0;
            op_inc     <= 1'b0;
            addr       <= '0;
            shift_reg  <= '0;
            rd_reg     <= '0;
            wr_reg     <= '0;
            busy_q     <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            sram_drv_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            op_rd      <= op_rd_nxt;
            op_inc     <= op_inc_nxt;
            busy_q     <= busy_nxt;
            ce_n_q     <= ce_n_nxt;
            oe_n_q     <= oe_n_nxt;
            we_n_q     <= we_n_nxt;
            sram_drv_q <= sram_drv_nxt;

            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if ((state == STROBE) && !strobe_last) begin
                wait_cnt <= wait_cnt + 4'd1;
            end

            if (cmd_vld) begin
                case (bus.avr_ctrl)
                    CMD_SHIFT:                shift_reg <= {shift_reg[ADDR_W-2:0], bus.avr_si};
                    CMD_LOAD:                 addr      <= shift_reg;
                    CMD_WRITE, CMD_WRITE_INC: wr_reg    <= avr_data;
                    CMD_CLR: begin
                        addr      <= '0;
                        shift_reg <= '0;
                    end
                    default: ;
                endcase
            end

            // Read data is taken at the end of the strobe window, while oe_n is still low.
            if ((state == STROBE) && strobe_last && op_rd) begin
                rd_reg <= sram_data;
            end

            // Increment on the HOLD exit edge, the same edge ce_n rises, so the address never moves under an active chip enable.
            if ((state == HOLD) && op_inc) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign bus.avr_busy  = busy_q;
    assign bus.sram_addr = addr;
    assign bus.sram_ce_n = ce_n_q;
    assign bus.sram_oe_n = oe_n_q;
    assign bus.sram_we_n = we_n_q;

    assign sram_data = sram_drv_q ? wr_reg : {DATA_W{1'bz}};
    assign avr_data  = (!bus.avr_oe && !busy_q) ? rd_reg : {DATA_W{1'bz}};
endmodule

// File: tb/tb_sram_bridge.sv
// Self-checking bench for sram_bridge: directed steps, then randomized accesses, checked against an address/memory model.
// The external SRAM is a behavioural device with address-derived pre-contents.
// Released buses are probed by driving 0 from the bench; any DUT drive shows up as a nonzero or unknown value.
module tb_sram_bridge;
    localparam int ADDR_W = 21;
    localparam int DATA_W = 8;
    localparam int WS     = 1;

    logic              avr_clk = 1'b0;
    logic              avr_rst_n;
    wire  [DATA_W-1:0] avr_data;
    wire  [DATA_W-1:0] sram_data;
    logic              tb_avr_en;
    logic [DATA_W-1:0] tb_avr_dat;
    logic              sram_probe;
    logic [DATA_W-1:0] dev_rd = '0;
    int                checks = 0;
    int                failures = 0;

    sram_bridge_if #(.ADDR_W(ADDR_W)) bus ();

    sram_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_STATES(WS)) dut (
        .avr_clk   (avr_clk),
        .avr_rst_n (avr_rst_n),
        .bus       (bus.slave),
        .avr_data  (avr_data),
        .sram_data (sram_data)
    );

    always #5 avr_clk = ~avr_clk;

    assign avr_data  = tb_avr_en ? tb_avr_dat : 8'bz;
    assign sram_data = (!bus.sram_ce_n && !bus.sram_oe_n) ? dev_rd : (sram_probe ? 8'h00 : 8'bz);

    // Power-up contents of the SRAM, shared by the device and the model.
    function automatic logic [7:0] init_val(input logic [20:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // External SRAM device.
    logic [7:0] dev_mem [logic [20:0]];
    always @(posedge avr_clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n) dev_mem[bus.sram_addr] = sram_data;
    end
    always @(negedge avr_clk) begin
        dev_rd = dev_mem.exists(bus.sram_addr) ? dev_mem[bus.sram_addr] : init_val(bus.sram_addr);
    end

    // Reference model.
    logic [20:0] m_addr = '0;
    logic [20:0] m_shift = '0;
    logic [7:0]  m_rd = '0;
    logic [7:0]  ref_mem [logic [20:0]];

    function automatic logic [7:0] ref_read(input logic [20:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic [2:0] c, input logic si);
        bus.avr_ctrl = c;
        bus.avr_si   = si;
        bus.avr_req  = 1'b1;
        @(negedge avr_clk);
        bus.avr_req  = 1'b0;
        case (c)
            3'd1: m_shift = {m_shift[19:0], si};
            3'd2: m_addr  = m_shift;
            3'd7: begin m_addr = '0; m_shift = '0; end
            default: ;
        endcase
    endtask

    task automatic load_addr(input logic [20:0] a);
        for (int i = ADDR_W - 1; i >= 0; i--) cmd(3'd1, a[i]);
        cmd(3'd2, 1'b0);
        check("load_addr", bus.sram_addr, m_addr);
    endtask

    task automatic access(input logic [2:0] c, input logic [7:0] wd, input bit spam, input bit oe_busy);
        bit          is_wr, is_rd, is_inc;
        int          n, we_cnt, oe_cnt;
        logic [20:0] a0;
        is_wr  = (c == 3'd4) || (c == 3'd6);
        is_rd  = (c == 3'd3) || (c == 3'd5);
        is_inc = (c == 3'd5) || (c == 3'd6);
        a0     = m_addr;
        n = 0; we_cnt = 0; oe_cnt = 0;
        sram_probe   = 1'b0;
        bus.avr_ctrl = c;
        bus.avr_req  = 1'b1;
        tb_avr_en    = is_wr;
        tb_avr_dat   = wd;
        @(negedge avr_clk);
        bus.avr_req  = 1'b0;
        tb_avr_en    = 1'b0;
        if (oe_busy) begin
            bus.avr_oe = 1'b0;
            tb_avr_en  = 1'b1;
            tb_avr_dat = 8'h00;
        end
        while (bus.avr_busy === 1'b1 && n < 20) begin
            check("acc_ce_low", bus.sram_ce_n, 1'b0);
            check("acc_addr_stable", bus.sram_addr, a0);
            if (is_wr) begin
                check("wr_data_on_bus", sram_data, wd);
                check("wr_oe_high", bus.sram_oe_n, 1'b1);
            end else begin
                check("rd_we_high", bus.sram_we_n, 1'b1);
            end
            if (oe_busy) check("avr_data_released_busy", avr_data, 8'h00);
            if (bus.sram_we_n === 1'b0) we_cnt++;
            if (bus.sram_oe_n === 1'b0) oe_cnt++;
            if (spam) begin
                bus.avr_ctrl = 3'd3;
                bus.avr_req  = 1'b1;
            end
            n++;
            @(negedge avr_clk);
        end
        bus.avr_req = 1'b0;
        tb_avr_en   = 1'b0;
        bus.avr_oe  = 1'b1;
        check("busy_len", n, WS + 2);
        check("we_pulse_len", we_cnt, is_wr ? WS : 0);
        check("oe_pulse_len", oe_cnt, is_rd ? WS + 1 : 0);
        if (is_wr) ref_mem[a0] = wd;
        if (is_rd) m_rd = ref_read(a0);
        if (is_inc) m_addr = m_addr + 21'd1;
        check("addr_after", bus.sram_addr, m_addr);
        check("ce_high_after", bus.sram_ce_n, 1'b1);
        sram_probe = 1'b1;
        #1;
        check("sram_data_released", sram_data, 8'h00);
        bus.avr_oe = 1'b0;
        #1;
        check("rd_data", avr_data, m_rd);
        bus.avr_oe = 1'b1;
    endtask

    logic [7:0] stream_exp [3];

    initial begin
        bus.avr_req  = 1'b0;
        bus.avr_ctrl = 3'd0;
        bus.avr_si   = 1'b0;
        bus.avr_oe   = 1'b1;
        tb_avr_en    = 1'b0;
        tb_avr_dat   = 8'h00;
        sram_probe   = 1'b1;
        avr_rst_n    = 1'b0;
        repeat (2) @(negedge avr_clk);

        // Reset state.
        check("rst_ce_n", bus.sram_ce_n, 1'b1);
        check("rst_oe_n", bus.sram_oe_n, 1'b1);
        check("rst_we_n", bus.sram_we_n, 1'b1);
        check("rst_addr", bus.sram_addr, 21'h0);
        check("rst_busy", bus.avr_busy, 1'b0);
        check("rst_sram_data_released", sram_data, 8'h00);
        tb_avr_en = 1'b1;
        #1;
        check("rst_avr_data_released", avr_data, 8'h00);
        tb_avr_en = 1'b0;
        avr_rst_n = 1'b1;
        @(negedge avr_clk);

        // Address load, CLR, NOP.
        load_addr(21'h0A5A5);
        check("load_0a5a5", bus.sram_addr, 21'h0A5A5);
        cmd(3'd7, 1'b0);
        check("clr_addr", bus.sram_addr, 21'h0);
        cmd(3'd2, 1'b0);
        check("clr_shift_then_load", bus.sram_addr, 21'h0);
        load_addr(21'h00010);
        cmd(3'd0, 1'b0);
        check("nop_addr", bus.sram_addr, 21'h00010);
        check("nop_busy", bus.avr_busy, 1'b0);

        // Write 0x3C at 0x10, read it back (avr_oe held low through busy).
        access(3'd4, 8'h3C, 1'b0, 1'b0);
        access(3'd3, 8'h00, 1'b0, 1'b1);
        bus.avr_oe = 1'b0;
        #1;
        check("read_back_3c", avr_data, 8'h3C);
        bus.avr_oe = 1'b1;
        #1;
        check("avr_data_released_oe_high", avr_data, 8'h00);

        // Streaming writes across the address wrap.
        stream_exp[0] = 8'h11; stream_exp[1] = 8'h22; stream_exp[2] = 8'h33;
        load_addr(21'h1FFFFE);
        for (int i = 0; i < 3; i++) access(3'd6, stream_exp[i], 1'b0, 1'b0);
        check("stream_final_addr", bus.sram_addr, 21'h000001);
        load_addr(21'h1FFFFE);
        for (int i = 0; i < 3; i++) begin
            access(3'd5, 8'h00, 1'b0, 1'b0);
            bus.avr_oe = 1'b0;
            #1;
            check("stream_read", avr_data, stream_exp[i]);
            bus.avr_oe = 1'b1;
        end
        check("stream_read_final_addr", bus.sram_addr, 21'h000001);

        // Commands presented while busy are dropped.
        load_addr(21'h00040);
        access(3'd4, 8'h77, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge avr_clk);
            check("drop_no_busy", bus.avr_busy, 1'b0);
            check("drop_addr", bus.sram_addr, 21'h00040);
        end

        // Randomized accesses.
        for (int it = 0; it < 24; it++) begin
            logic [2:0] c;
            if ($urandom_range(0, 4) == 0) begin
                if ($urandom_range(0, 1) == 1) load_addr(21'h1FFFFC + 21'($urandom_range(0, 3)));
                else load_addr(21'($urandom_range(0, 7)));
            end
            case ($urandom_range(0, 3))
                0:       c = 3'd3;
                1:       c = 3'd4;
                2:       c = 3'd5;
                default: c = 3'd6;
            endcase
            access(c, 8'($urandom), 1'b0, 1'b0);
        end

        // Reset in the middle of a WRITE_INC strobe.
        load_addr(21'h00123);
        sram_probe   = 1'b0;
        bus.avr_ctrl = 3'd6;
        bus.avr_req  = 1'b1;
        tb_avr_en    = 1'b1;
        tb_avr_dat   = 8'h99;
        @(negedge avr_clk);
        bus.avr_req  = 1'b0;
        tb_avr_en    = 1'b0;
        @(negedge avr_clk);
        check("pre_rst_we_low", bus.sram_we_n, 1'b0);
        avr_rst_n = 1'b0;
        @(negedge avr_clk);
        m_addr = '0; m_shift = '0; m_rd = '0;
        check("midrst_we_n", bus.sram_we_n, 1'b1);
        check("midrst_ce_n", bus.sram_ce_n, 1'b1);
        check("midrst_oe_n", bus.sram_oe_n, 1'b1);
        check("midrst_addr", bus.sram_addr, 21'h0);
        check("midrst_busy", bus.avr_busy, 1'b0);
        sram_probe = 1'b1;
        #1;
        check("midrst_sram_released", sram_data, 8'h00);
        bus.avr_oe = 1'b0;
        #1;
        check("midrst_rd_cleared", avr_data, m_rd);
        bus.avr_oe = 1'b1;
        avr_rst_n = 1'b1;
        repeat (2) @(negedge avr_clk);
        check("midrst_no_inc", bus.sram_addr, m_addr);
        check("midrst_idle_busy", bus.avr_busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
